// File: rtl/ram_lsu.sv
// Load/store unit between the core memory stage and a word-organised data RAM.
// Byte/halfword stores are done as read-modify-write; loads are extracted and extended.
module ram_lsu #(
   parameter int  TAM_POSICIONES = 1024,
   parameter int  TAM_PALABRA    = 32,
   localparam int AW             = $clog2(TAM_POSICIONES)
) (
   input  logic                   CLK,
   input  logic                   RSTa,
   input  logic                   REQ,
   input  logic                   WE_REQ,
   input  logic [2:0]             FUNCT3,
   input  logic [31:0]            ADDR_REQ,
   input  logic [31:0]            WDATA,
   output logic                   BUSY,
   output logic                   DONE,
   output logic                   ERR,
   output logic [31:0]            RDATA,
   output logic                   RAM_WR,
   output logic                   RAM_OE,
   output logic [AW-1:0]          RAM_ADDRESS,
   output logic [TAM_PALABRA-1:0] RAM_DATA_IN,
   input  logic [TAM_PALABRA-1:0] RAM_DATA_OUT
);

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

   state_t                   state_q;
   logic                     we_q;
   logic [2:0]               f3_q;
   logic [AW+1:0]            addr_q;
   logic [31:0]              wdata_q;
   logic [TAM_PALABRA-1:0]   word_q;
   logic [31:0]              rdata_q;
   logic                     busy_q;
   logic                     done_q;
   logic                     err_q;
   logic                     wr_q;
   logic                     oe_q;

   logic                     req_illegal;
   logic                     req_misaligned;
   logic                     req_bad;
   logic                     unused_addr_hi;

   function automatic logic [31:0] merge_store(input logic [31:0] old_w,
                                               input logic [31:0] wd,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lane);
      logic [31:0] w;
      w = old_w;
      case (f3[1:0])
         2'b00:   w[{lane, 3'b000} +: 8]     = wd[7:0];
         2'b01:   w[{lane[1], 4'b0000} +: 16] = wd[15:0];
         default: w = wd;
      endcase
      return w;
   endfunction

   function automatic logic [31:0] extract_load(input logic [31:0] w,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [31:0]        r;
      b = w[{lane, 3'b000} +: 8];
      h = w[{lane[1], 4'b0000} +: 16];
      case (f3)
         F3_B:    r = {{24{b[7]}}, b};
         F3_BU:   r = {24'd0, b};
         F3_H:    r = {{16{h[15]}}, h};
         F3_HU:   r = {16'd0, h};
         default: r = w;
      endcase
      return r;
   endfunction

   assign req_illegal    = (FUNCT3 == 3'b011) || (FUNCT3[2:1] == 2'b11) ||
                           (WE_REQ && (FUNCT3 == F3_BU || FUNCT3 == F3_HU));
   assign req_misaligned = ((FUNCT3 == F3_H || FUNCT3 == F3_HU) && ADDR_REQ[0]) ||
                           ((FUNCT3 == F3_W) && (ADDR_REQ[1:0] != 2'b00));
   assign req_bad        = req_illegal || req_misaligned;

   // Word index bits above the RAM depth are dropped, so addresses wrap.
   assign unused_addr_hi = ^ADDR_REQ[31:AW+2];

   always_ff @(posedge CLK or negedge RSTa) begin
      if (!RSTa) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         word_q  <= '0;
         rdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         wr_q    <= 1'b0;
         oe_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (REQ) begin
                  we_q    <= WE_REQ;
                  f3_q    <= FUNCT3;
                  addr_q  <= ADDR_REQ[AW+1:0];
                  wdata_q <= WDATA;
                  busy_q  <= 1'b1;
                  if (req_bad) begin
                     state_q <= S_RESP;
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                  end else if (WE_REQ && FUNCT3 == F3_W) begin
                     state_q <= S_WRITE;
                     wr_q    <= 1'b1;
                  end else begin
                     state_q <= S_READ;
                     oe_q    <= 1'b1;
                  end
               end
            end
            S_READ: begin
               oe_q   <= 1'b0;
               word_q <= RAM_DATA_OUT;
               if (we_q) begin
                  state_q <= S_WRITE;
                  wr_q    <= 1'b1;
               end else begin
                  rdata_q <= extract_load(RAM_DATA_OUT, f3_q, addr_q[1:0]);
                  state_q <= S_RESP;
                  done_q  <= 1'b1;
               end
            end
            S_WRITE: begin
               wr_q    <= 1'b0;
               state_q <= S_RESP;
               done_q  <= 1'b1;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign BUSY        = busy_q;
   assign DONE        = done_q;
   assign ERR         = err_q;
   assign RDATA       = rdata_q;
   assign RAM_WR      = wr_q;
   assign RAM_OE      = oe_q;
   assign RAM_ADDRESS = addr_q[AW+1:2];
   // For SW the merge passes WDATA through; the captured word only matters for SB/SH.
   assign RAM_DATA_IN = merge_store(word_q, wdata_q, f3_q, addr_q[1:0]);

endmodule

// File: tb/tb_ram_lsu.sv
// Bench for ram_lsu: bench-owned RAM, byte-level reference memory, directed table,
// hand-written multi-cycle sequences and randomized requests.
module tb_ram_lsu;

   localparam int AW    = 10;
   localparam int WORDS = 1024;

   logic        CLK = 1'b0;
   logic        RSTa;
   logic        REQ;
   logic        WE_REQ;
   logic [2:0]  FUNCT3;
   logic [31:0] ADDR_REQ;
   logic [31:0] WDATA;
   logic        BUSY;
   logic        DONE;
   logic        ERR;
   logic [31:0] RDATA;
   logic        RAM_WR;
   logic        RAM_OE;
   logic [AW-1:0] RAM_ADDRESS;
   logic [31:0] RAM_DATA_IN;
   logic [31:0] RAM_DATA_OUT;

   ram_lsu #(.TAM_POSICIONES(WORDS), .TAM_PALABRA(32)) dut (
      .CLK(CLK), .RSTa(RSTa), .REQ(REQ), .WE_REQ(WE_REQ), .FUNCT3(FUNCT3),
      .ADDR_REQ(ADDR_REQ), .WDATA(WDATA), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
      .RDATA(RDATA), .RAM_WR(RAM_WR), .RAM_OE(RAM_OE), .RAM_ADDRESS(RAM_ADDRESS),
      .RAM_DATA_IN(RAM_DATA_IN), .RAM_DATA_OUT(RAM_DATA_OUT)
   );

   always #5 CLK = ~CLK;

   logic [31:0] ram  [WORDS];
   logic [31:0] seed [WORDS];
   logic        ram_load;

   always @(posedge CLK) begin
      if (ram_load) begin
         for (int i = 0; i < WORDS; i++) ram[i] <= seed[i];
      end else if (RAM_WR) begin
         ram[RAM_ADDRESS] <= RAM_DATA_IN;
      end
   end

   assign RAM_DATA_OUT = (RAM_OE && !RAM_WR) ? ram[RAM_ADDRESS] : 32'hBAAD_F00D;

   // reference model: byte-addressed memory plus the last successful load result
   logic [7:0]  rmem [WORDS*4];
   logic [31:0] ref_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      int          cyc;
      logic        err;
      logic [31:0] rd;
      int          widx;
      logic [31:0] word;
      logic        chkw;
   } vec_t;

   vec_t tv [17];

   function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd,
                               int cyc, logic err, logic [31:0] rd, int widx,
                               logic [31:0] word, logic chkw);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = addr; v.wd = wd; v.cyc = cyc; v.err = err;
      v.rd = rd; v.widx = widx; v.word = word; v.chkw = chkw;
      return v;
   endfunction

   function automatic logic [31:0] mword(int w);
      return {rmem[4*w+3], rmem[4*w+2], rmem[4*w+1], rmem[4*w]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h want %08h", nm, act, exp);
      end
   endtask

   task automatic ref_apply(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, output int ecyc, output logic eerr,
                            output int ewr, output int eoe);
      int          b;
      int          n;
      logic [31:0] v;
      b = int'(a[11:0]);
      n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      eerr = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
             (we && (f3 == 3'd4 || f3 == 3'd5)) || ((b % n) != 0);
      ecyc = 1; ewr = 0; eoe = 0;
      if (!eerr) begin
         if (we) begin
            for (int k = 0; k < n; k++) rmem[b+k] = 8'(wd >> (8*k));
            ewr  = 1;
            eoe  = (n < 4) ? 1 : 0;
            ecyc = (n < 4) ? 3 : 2;
         end else begin
            v = 0;
            for (int k = 0; k < n; k++) v = v + (32'(rmem[b+k]) << (8*k));
            if (!f3[2] && n < 4 && v >= (32'd1 << (8*n-1))) v = v - (32'd1 << (8*n));
            ref_rdata = v;
            eoe  = 1;
            ecyc = 2;
         end
      end
   endtask

   task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int cyc, output logic err,
                          output logic [31:0] rd, output int nwr, output int noe,
                          output int nboth, output logic [AW-1:0] obs_addr);
      @(negedge CLK);
      WE_REQ = we; FUNCT3 = f3; ADDR_REQ = a; WDATA = wd; REQ = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      REQ = 1'b0;
      cyc = -1; err = 1'b0; rd = '0; nwr = 0; noe = 0; nboth = 0; obs_addr = '0;
      for (int c = 1; c <= 8; c++) begin
         if (RAM_WR) nwr++;
         if (RAM_OE) noe++;
         if (RAM_WR && RAM_OE) nboth++;
         if (RAM_WR || RAM_OE) obs_addr = RAM_ADDRESS;
         if (DONE) begin
            cyc = c; err = ERR; rd = RDATA;
            break;
         end
         @(negedge CLK);
      end
   endtask

   task automatic check_req(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            output int cyc, output logic err, output logic [31:0] rd);
      int          ecyc, ewr, eoe, nwr, noe, nboth;
      logic        eerr;
      logic [AW-1:0] oa;
      ref_apply(we, f3, a, wd, ecyc, eerr, ewr, eoe);
      run_req(we, f3, a, wd, cyc, err, rd, nwr, noe, nboth, oa);
      chk({tag, "_cycles"}, 32'(cyc), 32'(ecyc));
      chk({tag, "_err"}, 32'(err), 32'(eerr));
      chk({tag, "_rdata"}, rd, ref_rdata);
      chk({tag, "_wr_cycles"}, 32'(nwr), 32'(ewr));
      chk({tag, "_oe_cycles"}, 32'(noe), 32'(eoe));
      chk({tag, "_wr_oe_overlap"}, 32'(nboth), 32'd0);
      if (!eerr) chk({tag, "_ram_addr"}, 32'(oa), 32'(a[11:2]));
   endtask

   initial begin
      int          cyc;
      logic        err;
      logic [31:0] rd;
      int          ecyc, ewr, eoe, bad;
      logic        eerr;
      logic [9:0]  done_pat, busy_pat;

      RSTa = 1'b0; REQ = 1'b0; WE_REQ = 1'b0; FUNCT3 = 3'd0; ADDR_REQ = '0; WDATA = '0;
      ram_load = 1'b0;
      for (int i = 0; i < WORDS; i++) begin
         seed[i] = $urandom;
         for (int k = 0; k < 4; k++) rmem[4*i+k] = 8'(seed[i] >> (8*k));
      end
      ref_rdata = '0;
      @(negedge CLK);
      ram_load = 1'b1;
      @(negedge CLK);
      ram_load = 1'b0;
      @(negedge CLK);
      RSTa = 1'b1;
      @(negedge CLK);

      chk("reset_busy_done_err", {29'd0, BUSY, DONE, ERR}, 32'd0);
      chk("reset_rdata", RDATA, 32'd0);
      chk("reset_wr_oe", {30'd0, RAM_WR, RAM_OE}, 32'd0);
      chk("reset_ram_addr", 32'(RAM_ADDRESS), 32'd0);
      chk("reset_ram_din", RAM_DATA_IN, 32'd0);

      tv[0]  = mk(1'b1, 3'd2, 32'h10,   32'hDEADBEEF, 2, 1'b0, 32'h0,        4, 32'hDEADBEEF, 1'b1);
      tv[1]  = mk(1'b0, 3'd2, 32'h10,   32'h0,        2, 1'b0, 32'hDEADBEEF, 4, 32'hDEADBEEF, 1'b1);
      tv[2]  = mk(1'b1, 3'd0, 32'h11,   32'h000000AA, 3, 1'b0, 32'hDEADBEEF, 4, 32'hDEADAAEF, 1'b1);
      tv[3]  = mk(1'b1, 3'd2, 32'h10,   32'hDEADBEEF, 2, 1'b0, 32'hDEADBEEF, 4, 32'hDEADBEEF, 1'b1);
      tv[4]  = mk(1'b0, 3'd0, 32'h13,   32'h0,        2, 1'b0, 32'hFFFFFFDE, 4, 32'h0,        1'b0);
      tv[5]  = mk(1'b0, 3'd4, 32'h13,   32'h0,        2, 1'b0, 32'h000000DE, 4, 32'h0,        1'b0);
      tv[6]  = mk(1'b0, 3'd1, 32'h12,   32'h0,        2, 1'b0, 32'hFFFFDEAD, 4, 32'h0,        1'b0);
      tv[7]  = mk(1'b0, 3'd5, 32'h12,   32'h0,        2, 1'b0, 32'h0000DEAD, 4, 32'h0,        1'b0);
      tv[8]  = mk(1'b1, 3'd1, 32'h12,   32'h00001234, 3, 1'b0, 32'h0000DEAD, 4, 32'h1234BEEF, 1'b1);
      tv[9]  = mk(1'b0, 3'd2, 32'h12,   32'h0,        1, 1'b1, 32'h0000DEAD, 4, 32'h1234BEEF, 1'b1);
      tv[10] = mk(1'b1, 3'd1, 32'h01,   32'h5555,     1, 1'b1, 32'h0000DEAD, 4, 32'h1234BEEF, 1'b1);
      tv[11] = mk(1'b1, 3'd4, 32'h10,   32'h5555,     1, 1'b1, 32'h0000DEAD, 4, 32'h1234BEEF, 1'b1);
      tv[12] = mk(1'b0, 3'd3, 32'h10,   32'h0,        1, 1'b1, 32'h0000DEAD, 4, 32'h1234BEEF, 1'b1);
      tv[13] = mk(1'b1, 3'd2, 32'h1000, 32'hAAAA5555, 2, 1'b0, 32'h0000DEAD, 0, 32'hAAAA5555, 1'b1);
      tv[14] = mk(1'b0, 3'd2, 32'h0,    32'h0,        2, 1'b0, 32'hAAAA5555, 0, 32'hAAAA5555, 1'b1);
      tv[15] = mk(1'b1, 3'd0, 32'h13,   32'hFFFFFF7E, 3, 1'b0, 32'hAAAA5555, 4, 32'h7E34BEEF, 1'b1);
      tv[16] = mk(1'b0, 3'd0, 32'h13,   32'h0,        2, 1'b0, 32'h0000007E, 4, 32'h7E34BEEF, 1'b1);

      for (int i = 0; i < 17; i++) begin
         check_req($sformatf("vec%0d", i), tv[i].we, tv[i].f3, tv[i].addr, tv[i].wd, cyc, err, rd);
         chk($sformatf("vec%0d_tbl_cycles", i), 32'(cyc), 32'(tv[i].cyc));
         chk($sformatf("vec%0d_tbl_err", i), 32'(err), 32'(tv[i].err));
         chk($sformatf("vec%0d_tbl_rdata", i), rd, tv[i].rd);
         if (tv[i].chkw) chk($sformatf("vec%0d_tbl_word", i), ram[tv[i].widx], tv[i].word);
      end

      // REQ held high across three back-to-back loads
      ref_apply(1'b0, 3'd2, 32'h10, 32'h0, ecyc, eerr, ewr, eoe);
      done_pat = '0; busy_pat = '0;
      @(negedge CLK);
      WE_REQ = 1'b0; FUNCT3 = 3'd2; ADDR_REQ = 32'h10; WDATA = '0; REQ = 1'b1;
      @(posedge CLK);
      for (int c = 1; c <= 9; c++) begin
         @(negedge CLK);
         done_pat[c] = DONE;
         busy_pat[c] = BUSY;
      end
      REQ = 1'b0;
      chk("held_req_done_pattern", 32'(done_pat), 32'h124);
      chk("held_req_busy_pattern", 32'(busy_pat), 32'h1B6);
      chk("held_req_rdata", RDATA, ref_rdata);
      @(negedge CLK);
      @(negedge CLK);
      chk("held_req_idle_after", {31'd0, BUSY}, 32'd0);

      // asynchronous reset while the SB write cycle is on the RAM
      @(negedge CLK);
      WE_REQ = 1'b1; FUNCT3 = 3'd0; ADDR_REQ = 32'h21; WDATA = 32'h77; REQ = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      REQ = 1'b0;
      chk("rst_mid_read_oe", {31'd0, RAM_OE}, 32'd1);
      @(negedge CLK);
      chk("rst_mid_write_wr", {31'd0, RAM_WR}, 32'd1);
      #1 RSTa = 1'b0;
      #1;
      chk("rst_mid_wr_drop", {31'd0, RAM_WR}, 32'd0);
      chk("rst_mid_busy_done", {30'd0, BUSY, DONE}, 32'd0);
      @(negedge CLK);
      chk("rst_mid_no_done", {30'd0, DONE, RAM_WR}, 32'd0);
      RSTa = 1'b1;
      ref_rdata = '0;
      chk("rst_mid_word_untouched", ram[8], mword(8));
      chk("rst_mid_rdata_cleared", RDATA, 32'd0);
      check_req("after_rst_lw", 1'b0, 3'd2, 32'h20, 32'h0, cyc, err, rd);

      // randomized requests, concentrated on a few words with random upper address bits
      for (int i = 0; i < 300; i++) begin
         logic [31:0] a;
         a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
         check_req($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   a, $urandom, cyc, err, rd);
      end

      bad = 0;
      for (int w = 0; w < WORDS; w++) if (ram[w] !== mword(w)) bad++;
      chk("final_memory_words_bad", 32'(bad), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
